osc_slot_scheduler: RTL and testbench
=====================================

# osc_slot_scheduler

Frame-level sequencer for the time-multiplexed oscillator datapath. Once per sample frame it walks every voice/oscillator slot and drives the packed slot index `xxxx` consumed by the oscillator and NCO. It turns asynchronous note-on requests into per-voice phase-accumulator zero masks aligned to each voice's slots. It also emits a slot-valid/index stream delayed to line up with the sine lookup output.

## Interface
Parameters:
- `VOICES`, 8: voice count, power of two.
- `V_OSC`, 4: oscillators per voice, power of two.
- `V_WIDTH`, 3: log2(VOICES).
- `O_WIDTH`, 2: log2(V_OSC).
- `E_WIDTH`, 3: must equal O_WIDTH+1.
- `PIPE_LAT`, 8: clocks from `xxxx` to valid sine output, ≥1.

Ports:
- `OSC_CLK`  in  1  sole clock, rising edge.
- `iRST`  in  1  reset. Asynchronous, active-high.
- `frame_start`  in  1  single-clock pulse requesting one frame pass.
- `key_on`  in  1  single-clock note-on strobe.
- `key_on_voice`  in  V_WIDTH  voice number qualified by `key_on`.
- `clr_overrun`  in  1  clears `overrun`.
- `xxxx`  out  V_WIDTH+E_WIDTH  packed slot index: bit0 = half-slot phase, [O_WIDTH:1] = ox, [V_WIDTH+O_WIDTH:O_WIDTH+1] = vx.
- `slot_active`  out  1  `xxxx` is a live slot.
- `osc_accum_zero`  out  VOICES  per-voice accumulator clear mask.
- `frame_done`  out  1  one-clock end-of-frame pulse.
- `busy`  out  1  state ≠ IDLE.
- `out_valid`  out  1  `slot_active` delayed by PIPE_LAT.
- `out_vx`  out  V_WIDTH  vx delayed by PIPE_LAT.
- `out_ox`  out  O_WIDTH  ox delayed by PIPE_LAT.
- `overrun`  out  1  sticky: a frame request was lost.

## Operation
- Frame length N = VOICES·V_OSC·2 clocks. Defaults give N = 64.
- Slot counter `xxxx` counts 0..N−1, linearly. Bit0 toggles every clock, then ox increments, then vx.
- FSM states:
  - IDLE: `xxxx` = 0, `slot_active` = 0. `frame_start` → RUN.
  - RUN: `slot_active` = 1, counter increments each clock. At count N−1 → DONE.
  - DONE: `frame_done` = 1 for one clock, counter cleared → IDLE.
- Overrun:
  - `frame_start` is accepted only in IDLE.
  - Any `frame_start` seen in RUN or DONE is dropped and sets `overrun`.
  - `clr_overrun` clears `overrun`. If `clr_overrun` and a new overrun occur in the same clock, set wins.
- Note-on handling:
  - `key_on` sets `pending[key_on_voice]` in any state. Repeated requests for an already-pending voice merge.
  - Capture point for voice v: the RUN cycle with vx = v, ox = 0, bit0 = 0.
  - At capture, if `pending[v]` is set: `osc_accum_zero[v]` = 1 for exactly 2·V_OSC clocks (all of v's slots), and `pending[v]` clears.
  - A `key_on` for v on v's capture cycle remains pending and is serviced next frame.
  - At most one bit of `osc_accum_zero` is high at any time.
- Output pipeline:
  - `out_valid`, `out_vx` and `out_ox` are a PIPE_LAT-deep shift of `slot_active`, vx and ox.
  - The pipeline shifts every clock regardless of state.

## Timing
- Reset values: IDLE; all outputs 0; `pending`, `overrun` and all delay stages 0. Reset mid-frame aborts immediately, with no `frame_done`.
- Start latency: `frame_start` at clock k → `slot_active` = 1 with `xxxx` = 0 at clock k+1.
- Last slot (`xxxx` = N−1) at k+N. `frame_done` at k+N+1. Earliest next accepted `frame_start` at k+N+2.
- `osc_accum_zero[v]` rises in the same clock as `xxxx` = v·2·V_OSC and falls after `xxxx` = (v+1)·2·V_OSC−1.
- `out_*` at clock t equals `slot_active`/vx/ox at t−PIPE_LAT.
- `key_on` at clock t is visible in `pending` at t+1. It is serviceable at a capture cycle ≥ t+1.

## Structure
- Package `osc_sched_pkg`:
  - FSM state enum (IDLE, RUN, DONE).
  - Localparams: SLOTS = VOICES·V_OSC·2, SLOT_W = V_WIDTH+E_WIDTH.
  - Field-extract helpers for vx, ox and phase from `xxxx`.
- Sub-module `osc_slot_delay`: parameterized-width, PIPE_LAT-deep shift register with async active-high clear. It carries {valid, vx, ox}.
- Top module holds the FSM, slot counter, pending/zero logic and overrun flag.

## Test plan
- Basic frame: single `frame_start` at clock 10 → `xxxx` runs 0..63 over clocks 11..74, `frame_done` = 1 at 75, `busy` = 0 at 76.
- Note-on: `key_on` voice 3 while idle, then frame → `osc_accum_zero` = 8'h08 exactly during `xxxx` 24..31; `pending[3]` = 0 afterwards; a second frame has no zero assertion.
- Collision: `key_on` voice 5 on its capture cycle (`xxxx` = 40) with voice 5 already pending → zero during 40..47 this frame, and again during 40..47 next frame.
- Overrun: `frame_start` at `xxxx` = 20 → frame completes normally, `overrun` = 1 until `clr_overrun`; `frame_start` in DONE also sets it.
- Pipeline alignment: `out_valid` first high 8 clocks after `slot_active`; `out_vx`/`out_ox` = 0/0, then 0/0, then 0/1, ...; `out_valid` drops 8 clocks after the frame ends.
- Reset mid-frame: `iRST` at `xxxx` = 33 with voice 4 pending → all outputs 0 asynchronously, no `frame_done`; next frame shows no zero for voice 4.

Source files
------------

// File: rtl/osc_sched_pkg.sv
// rtl/osc_sched_pkg.sv - shared types, default geometry and slot-index field helpers
package osc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    localparam int DEF_VOICES   = 8;
    localparam int DEF_V_OSC    = 4;
    localparam int DEF_V_WIDTH  = 3;
    localparam int DEF_O_WIDTH  = 2;
    localparam int DEF_E_WIDTH  = 3;
    localparam int DEF_PIPE_LAT = 8;

    localparam int SLOTS  = DEF_VOICES * DEF_V_OSC * 2;
    localparam int SLOT_W = DEF_V_WIDTH + DEF_E_WIDTH;

    // Helpers assume the default geometry; the top slices with its own parameters.
    function automatic logic [DEF_V_WIDTH-1:0] slot_vx(input logic [SLOT_W-1:0] x);
        return x[SLOT_W-1:DEF_E_WIDTH];
    endfunction

    function automatic logic [DEF_O_WIDTH-1:0] slot_ox(input logic [SLOT_W-1:0] x);
        return x[DEF_O_WIDTH:1];
    endfunction

    function automatic logic slot_phase(input logic [SLOT_W-1:0] x);
        return x[0];
    endfunction

    function automatic logic slot_is_last(input logic [SLOT_W-1:0] x);
        return x == SLOT_W'(SLOTS - 1);
    endfunction

endpackage

// File: rtl/osc_slot_delay.sv
// rtl/osc_slot_delay.sv - fixed-depth shift register aligning slot info with the sine output
module osc_slot_delay #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8
) (
    input  logic             OSC_CLK,
    input  logic             iRST,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge OSC_CLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/osc_slot_scheduler.sv
// rtl/osc_slot_scheduler.sv - per-frame slot walker with note-on accumulator clears and overrun flag
module osc_slot_scheduler
    import osc_sched_pkg::*;
#(
    parameter int VOICES   = DEF_VOICES,
    parameter int V_OSC    = DEF_V_OSC,
    parameter int V_WIDTH  = DEF_V_WIDTH,
    parameter int O_WIDTH  = DEF_O_WIDTH,
    parameter int E_WIDTH  = DEF_E_WIDTH,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic                       OSC_CLK,
    input  logic                       iRST,
    input  logic                       frame_start,
    input  logic                       key_on,
    input  logic [V_WIDTH-1:0]         key_on_voice,
    input  logic                       clr_overrun,
    output logic [V_WIDTH+E_WIDTH-1:0] xxxx,
    output logic                       slot_active,
    output logic [VOICES-1:0]          osc_accum_zero,
    output logic                       frame_done,
    output logic                       busy,
    output logic                       out_valid,
    output logic [V_WIDTH-1:0]         out_vx,
    output logic [O_WIDTH-1:0]         out_ox,
    output logic                       overrun
);

    localparam int SW = V_WIDTH + E_WIDTH;
    localparam logic [SW-1:0] LAST = SW'(VOICES * V_OSC * 2 - 1);

    sched_state_e      state, state_n;
    logic [SW-1:0]     cnt, cnt_n;
    logic [VOICES-1:0] pending, pending_n, set_mask, clr_mask, zero_q, zero_n;
    logic [V_WIDTH-1:0] vx, vx_n;
    logic              capture;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (frame_start) begin
                state_n = RUN;
                cnt_n   = '0;
            end
            RUN: if (cnt == LAST) begin
                state_n = DONE;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + SW'(1);
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Capture clears the serviced voice; a same-cycle key_on re-arms it for next frame.
    always_comb begin
        vx        = cnt[SW-1:E_WIDTH];
        vx_n      = cnt_n[SW-1:E_WIDTH];
        capture   = (state == RUN) && (cnt[E_WIDTH-1:0] == '0);
        set_mask  = key_on ? (VOICES'(1) << key_on_voice) : '0;
        clr_mask  = (capture && pending[vx]) ? (VOICES'(1) << vx) : '0;
        pending_n = (pending & ~clr_mask) | set_mask;
        zero_n    = '0;
        if (state_n == RUN) begin
            if (cnt_n[E_WIDTH-1:0] == '0)
                zero_n = pending_n[vx_n] ? (VOICES'(1) << vx_n) : '0;
            else
                zero_n = zero_q;
        end
    end

    always_ff @(posedge OSC_CLK or posedge iRST) begin
        if (iRST) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= '0;
            zero_q  <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pending <= pending_n;
            zero_q  <= zero_n;
            if (frame_start && (state != IDLE))
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

    assign xxxx           = cnt;
    assign slot_active    = (state == RUN);
    assign frame_done     = (state == DONE);
    assign busy           = (state != IDLE);
    assign osc_accum_zero = zero_q;

    osc_slot_delay #(
        .WIDTH(1 + V_WIDTH + O_WIDTH),
        .DEPTH(PIPE_LAT)
    ) u_delay (
        .OSC_CLK(OSC_CLK),
        .iRST   (iRST),
        .din    ({slot_active, cnt[SW-1:E_WIDTH], cnt[O_WIDTH:1]}),
        .dout   ({out_valid, out_vx, out_ox})
    );

endmodule

// File: tb/tb_osc_slot_scheduler.sv
// tb/tb_osc_slot_scheduler.sv - table-driven frame checks plus reset and overrun sequences
module tb_osc_slot_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_start = 1'b0;
    logic       key_on = 1'b0;
    logic [2:0] key_on_voice = '0;
    logic       clr_overrun = 1'b0;
    logic [5:0] xxxx;
    logic       slot_active;
    logic [7:0] osc_accum_zero;
    logic       frame_done;
    logic       busy;
    logic       out_valid;
    logic [2:0] out_vx;
    logic [1:0] out_ox;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    osc_slot_scheduler dut (
        .OSC_CLK       (clk),
        .iRST          (rst),
        .frame_start   (frame_start),
        .key_on        (key_on),
        .key_on_voice  (key_on_voice),
        .clr_overrun   (clr_overrun),
        .xxxx          (xxxx),
        .slot_active   (slot_active),
        .osc_accum_zero(osc_accum_zero),
        .frame_done    (frame_done),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_vx        (out_vx),
        .out_ox        (out_ox),
        .overrun       (overrun)
    );

    typedef struct {
        logic [7:0] keys_before;
        int         key_i;
        int         key_v;
        int         fs_i;
        int         clr_i;
        logic [7:0] exp_zero;
        logic       exp_ovr;
        logic       clr_after;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic key_press(input int v);
        key_on       = 1'b1;
        key_on_voice = 3'(v);
        @(negedge clk);
        key_on = 1'b0;
    endtask

    // Called right after a negedge; frame cycle i is the i-th clock after acceptance.
    task automatic run_frame(input vec_t tv);
        logic [7:0] ez;
        int         j;
        for (int v = 0; v < 8; v++)
            if (tv.keys_before[v]) key_press(v);
        frame_start = 1'b1;
        for (int i = 0; i < 74; i++) begin
            @(negedge clk);
            if (i < 64) begin
                ez = tv.exp_zero[i/8] ? (8'h01 << (i/8)) : 8'h00;
                check("xxxx", xxxx, i);
                check("slot_active", slot_active, 1);
                check("accum_zero", osc_accum_zero, ez);
            end
            if (i == 0)  check("overrun_clear_at_start", overrun, 0);
            if (i == 64) begin
                check("frame_done", frame_done, 1);
                check("busy_in_done", busy, 1);
                check("xxxx_done", xxxx, 0);
                check("slot_active_done", slot_active, 0);
                check("zero_done", osc_accum_zero, 0);
            end
            if (i == 65) begin
                check("busy_idle", busy, 0);
                check("frame_done_idle", frame_done, 0);
            end
            check("out_valid", out_valid, (i >= 8 && i < 72) ? 1 : 0);
            if (i >= 8 && i < 72) begin
                j = i - 8;
                check("out_vx", out_vx, j / 8);
                check("out_ox", out_ox, (j / 2) % 4);
            end
            if (i == 73) check("overrun_after_frame", overrun, tv.exp_ovr);
            frame_start  = (i == tv.fs_i);
            key_on       = (i == tv.key_i);
            key_on_voice = 3'(tv.key_v);
            clr_overrun  = (i == tv.clr_i);
        end
        frame_start = 1'b0;
        key_on      = 1'b0;
        clr_overrun = 1'b0;
        if (tv.clr_after) begin
            clr_overrun = 1'b1;
            @(negedge clk);
            clr_overrun = 1'b0;
            check("overrun_cleared", overrun, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_xxxx"}, xxxx, 0);
        check({tag, "_slot_active"}, slot_active, 0);
        check({tag, "_zero"}, osc_accum_zero, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_vx"}, out_vx, 0);
        check({tag, "_out_ox"}, out_ox, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        vec_t tv;
        //            keys   key_i key_v fs_i clr_i  zero  ovr clr
        vecs[0]  = '{8'h00,  -1,   0,   -1,  -1,  8'h00, 0,  0};
        vecs[1]  = '{8'h08,  -1,   0,   -1,  -1,  8'h08, 0,  0};
        vecs[2]  = '{8'h00,  -1,   0,   -1,  -1,  8'h00, 0,  0};
        vecs[3]  = '{8'h20,  40,   5,   -1,  -1,  8'h20, 0,  0};
        vecs[4]  = '{8'h00,  -1,   0,   -1,  -1,  8'h20, 0,  0};
        vecs[5]  = '{8'h00,  -1,   0,   20,  -1,  8'h00, 1,  1};
        vecs[6]  = '{8'h00,  -1,   0,   64,  64,  8'h00, 1,  1};
        vecs[7]  = '{8'h81,  -1,   0,   -1,  -1,  8'h81, 0,  0};
        vecs[8]  = '{8'h00,  10,   6,   -1,  -1,  8'h40, 0,  0};
        vecs[9]  = '{8'h00,  16,   2,   -1,  -1,  8'h00, 0,  0};
        vecs[10] = '{8'h00,  -1,   0,   -1,  -1,  8'h04, 0,  0};

        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int n = 0; n < 11; n++) begin
            run_frame(vecs[n]);
            repeat (2) @(negedge clk);
        end

        // Reset mid-frame with voice 4 pending and its zero window active.
        key_press(4);
        frame_start = 1'b1;
        for (int i = 0; i <= 33; i++) begin
            @(negedge clk);
            frame_start = 1'b0;
            if (i == 33) begin
                check("pre_reset_xxxx", xxxx, 33);
                check("pre_reset_zero", osc_accum_zero, 8'h10);
            end
        end
        #2 rst = 1'b1;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_reset_no_done", {frame_done, busy}, 0);
        end
        tv = '{8'h00, -1, 0, -1, -1, 8'h00, 0, 0};
        run_frame(tv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
